// File: rtl/mem_stall_if.sv
// Memory-side and pipeline-side signal bundle for mem_stall_ctrl.
// The master modport is the controller; the slave modport is the pipeline/memory side.
interface mem_stall_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        ack;
  logic [31:0] rdata;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_out;
  logic        stall;
  logic        wb_en;
  logic        err;

  modport master (
    input  mem_rd, mem_wr, addr_in, wdata_in, ack, rdata,
    output req, we, addr, wdata, rdata_out, stall, wb_en, err
  );

  modport slave (
    output mem_rd, mem_wr, addr_in, wdata_in, ack, rdata,
    input  req, we, addr, wdata, rdata_out, stall, wb_en, err
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Stalls the pipeline around a single-outstanding memory request (IDLE/REQ/DONE).
// Optional request timeout with a sticky error state is enabled by MEM_STALL_TIMEOUT_EN.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_stall_if.master  bus
);

`ifdef MEM_STALL_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 32'd1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
`endif

  if ((TIMEOUT_CYC < 32'd2) || (TIMEOUT_CYC > 32'd65535)) begin : g_bad_timeout
    $error("mem_stall_ctrl: TIMEOUT_CYC out of range 2..65535");
  end

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_out_q, rdata_out_d;
`ifdef MEM_STALL_TIMEOUT_EN
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
`endif
  logic        stall_s;

  // Next-state and request-capture logic
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_out_d = rdata_out_q;
`ifdef MEM_STALL_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.mem_rd || bus.mem_wr) begin
          state_d = REQ;
          addr_d  = bus.addr_in;
          wdata_d = bus.wdata_in;
          // a store wins when both decode bits are set
          we_d    = bus.mem_wr;
`ifdef MEM_STALL_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.ack) begin
          if (!we_q) begin
            rdata_out_d = bus.rdata;
          end else begin
            rdata_out_d = rdata_out_q;
          end
          state_d = DONE;
        end else begin
`ifdef MEM_STALL_TIMEOUT_EN
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
`ifdef MEM_STALL_TIMEOUT_EN
      ERR: begin
        state_d = ERR;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d = (state_d == REQ);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rdata_out_q <= 32'd0;
`ifdef MEM_STALL_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_out_q <= rdata_out_d;
`ifdef MEM_STALL_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Stall is combinational so the PC freezes in the same cycle the access is decoded
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      IDLE:    stall_s = bus.mem_rd || bus.mem_wr;
      REQ:     stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
`ifdef MEM_STALL_TIMEOUT_EN
      ERR:     stall_s = 1'b1;
`endif
      default: stall_s = 1'b0;
    endcase
  end

  assign bus.req       = req_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rdata_out = rdata_out_q;
  assign bus.stall     = stall_s;
  assign bus.wb_en     = !stall_s;
`ifdef MEM_STALL_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl; load data expectations go through a scoreboard queue.
module tb_mem_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

`ifdef MEM_STALL_TIMEOUT_EN
  localparam int STORE_WAIT = 4;
`else
  localparam int STORE_WAIT = 5;
`endif

  mem_stall_if bus();

  mem_stall_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_rdata(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%h expected=<scoreboard entry, queue empty>", tag, bus.rdata_out);
    end else begin
      chk32(tag, bus.rdata_out, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.addr_in  = 32'd0;
    bus.wdata_in = 32'd0;
    bus.ack      = 1'b0;
    bus.rdata    = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1 ("rst_req",   bus.req,   1'b0);
    chk1 ("rst_we",    bus.we,    1'b0);
    chk32("rst_addr",  bus.addr,  32'd0);
    chk32("rst_wdata", bus.wdata, 32'd0);
    chk32("rst_rdata", bus.rdata_out, 32'd0);
    chk1 ("rst_err",   bus.err,   1'b0);
    chk1 ("rst_stall", bus.stall, 1'b0);

    // ten non-memory cycles; a stray ack in IDLE must be ignored
    for (int i = 0; i < 10; i++) begin
      bus.ack   = (i == 3);
      bus.rdata = 32'hFFFF_FFFF;
      #1;
      chk1("idle_stall", bus.stall, 1'b0);
      chk1("idle_wb_en", bus.wb_en, 1'b1);
      chk1("idle_req",   bus.req,   1'b0);
      tick();
    end
    bus.ack = 1'b0;
    #1;
    chk32("idle_ack_ignored", bus.rdata_out, 32'd0);

    // load, ack in first REQ cycle
    bus.mem_rd  = 1'b1;
    bus.addr_in = 32'h0000_0100;
    #1;
    chk1("ld_idle_stall", bus.stall, 1'b1);
    chk1("ld_idle_wb_en", bus.wb_en, 1'b0);
    chk1("ld_idle_req",   bus.req,   1'b0);
    tick();
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk1 ("ld_req",       bus.req,   1'b1);
    chk1 ("ld_we",        bus.we,    1'b0);
    chk32("ld_addr",      bus.addr,  32'h0000_0100);
    chk1 ("ld_req_stall", bus.stall, 1'b1);
    tick();
    bus.rdata = 32'h0BAD_0BAD;
    #1;
    chk1("ld_done_stall", bus.stall, 1'b0);
    chk1("ld_done_wb_en", bus.wb_en, 1'b1);
    chk1("ld_done_req",   bus.req,   1'b0);
    pop_rdata("ld_rdata_out");
    tick();
    bus.mem_rd = 1'b0;
    bus.ack    = 1'b0;
    #1;
    chk1 ("ld_back_idle",    bus.stall,     1'b0);
    chk32("ld_done_ack_ign", bus.rdata_out, 32'hDEAD_BEEF);

    // store, ack in the last of STORE_WAIT REQ cycles; inputs change after capture
    bus.mem_wr   = 1'b1;
    bus.addr_in  = 32'h0000_0200;
    bus.wdata_in = 32'h1234_5678;
    tick();
    bus.addr_in  = 32'hFFFF_0000;
    bus.wdata_in = 32'h0;
    for (int i = 0; i < STORE_WAIT; i++) begin
      if (i == STORE_WAIT - 1) begin
        bus.ack   = 1'b1;
        bus.rdata = 32'hCAFE_F00D;
        exp_q.push_back(32'hDEAD_BEEF);
      end else begin
        bus.ack = 1'b0;
      end
      #1;
      chk1 ("st_req",   bus.req,   1'b1);
      chk1 ("st_we",    bus.we,    1'b1);
      chk32("st_addr",  bus.addr,  32'h0000_0200);
      chk32("st_wdata", bus.wdata, 32'h1234_5678);
      chk1 ("st_stall", bus.stall, 1'b1);
      chk1 ("st_err",   bus.err,   1'b0);
      tick();
    end
    bus.ack = 1'b0;
    #1;
    chk1("st_done_req",   bus.req,   1'b0);
    chk1("st_done_stall", bus.stall, 1'b0);
    pop_rdata("st_rdata_kept");
    tick();
    bus.mem_wr = 1'b0;
    #1;
    chk1("st_back_idle", bus.stall, 1'b0);

    // simultaneous rd and wr: store wins
    bus.mem_rd  = 1'b1;
    bus.mem_wr  = 1'b1;
    bus.addr_in = 32'h0000_0300;
    tick();
    bus.ack   = 1'b1;
    bus.rdata = 32'h1111_1111;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk1("both_we",  bus.we,  1'b1);
    chk1("both_req", bus.req, 1'b1);
    tick();
    bus.ack    = 1'b0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    #1;
    pop_rdata("both_rdata_kept");
    tick();

    // reset in the 2nd REQ cycle, ack arrives afterwards
    bus.mem_rd  = 1'b1;
    bus.addr_in = 32'h0000_0400;
    tick();
    #1;
    chk1("rr_req1", bus.req, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk1("rr_req2", bus.req, 1'b1);
    tick();
    rst        = 1'b0;
    bus.mem_rd = 1'b0;
    bus.ack    = 1'b1;
    bus.rdata  = 32'h7777_7777;
    #1;
    chk1 ("rr_req_cleared", bus.req,       1'b0);
    chk1 ("rr_stall",       bus.stall,     1'b0);
    chk32("rr_addr",        bus.addr,      32'd0);
    chk32("rr_rdata_out",   bus.rdata_out, 32'd0);
    tick();
    bus.ack = 1'b0;
    #1;
    chk1 ("rr_late_req",  bus.req,       1'b0);
    chk32("rr_late_data", bus.rdata_out, 32'd0);

    // load that never gets an ack
    bus.mem_rd  = 1'b1;
    bus.addr_in = 32'h0000_0500;
    tick();
`ifdef MEM_STALL_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("to_req",   bus.req,   1'b1);
      chk1("to_err0",  bus.err,   1'b0);
      chk1("to_stall", bus.stall, 1'b1);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      bus.ack    = (j == 1);
      bus.mem_rd = (j != 2);
      #1;
      chk1("to_err1",      bus.err,   1'b1);
      chk1("to_err_req",   bus.req,   1'b0);
      chk1("to_err_stall", bus.stall, 1'b1);
      chk1("to_err_wb_en", bus.wb_en, 1'b0);
      tick();
    end
`else
    for (int i = 0; i < 100; i++) begin
      #1;
      chk1("wait_req", bus.req, 1'b1);
      chk1("wait_err", bus.err, 1'b0);
      tick();
    end
`endif
    bus.ack    = 1'b0;
    bus.mem_rd = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("end_err",   bus.err,   1'b0);
    chk1("end_req",   bus.req,   1'b0);
    chk1("end_stall", bus.stall, 1'b0);
    chk32("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
